dp784_layer_sequencer: RTL

- Sequences one DotProduct784 datapath across all output neurons of a 784-input layer.
- Per neuron:
  - clears the dot-product accumulator;
  - drives 28 row addresses to the pixel and weight memories (28 pixels + 28 weights per row);
  - waits out memory and pipeline latency;
  - captures the 26-bit score.
- Keeps a running signed argmax and reports the winning class after the final neuron.
- Sits between the top-level control FSM and the DotProduct784 instance and its operand memories.

---
 rtl/dp784_layer_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dp784_layer_sequencer.sv
// Layer sequencer for one DotProduct784 datapath: walks every output neuron,
// feeds row addresses, captures each score and tracks the signed argmax.
module dp784_layer_sequencer #(
    parameter int unsigned NEURONS      = 10,
    parameter int unsigned ROWS         = 28,
    parameter int unsigned DRAIN_CYCLES = 12,
    parameter int unsigned VAL_W        = 26
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             dp_clear,
    output logic             row_valid,
    output logic [4:0]       row_addr,
    output logic [3:0]       neuron_idx,
    input  logic [VAL_W-1:0] dp_value,
    output logic             score_valid,
    output logic [3:0]       score_idx,
    output logic [VAL_W-1:0] score_out,
    output logic [3:0]       class_id,
    output logic [VAL_W-1:0] class_score
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [4:0]    LAST_ROW    = 5'(ROWS - 1);
    localparam logic [3:0]    LAST_NEURON = 4'(NEURONS - 1);
    localparam logic [DW-1:0] DRAIN_LOAD  = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                    state, state_nx;
    logic [DW-1:0]             drain_cnt;
    logic                      best_valid;
    logic [3:0]                best_idx;
    logic signed [VAL_W-1:0]   best_score;
    logic                      take_new;

    // Strict greater-than keeps the earlier (lower) index on ties.
    always_comb begin
        take_new = !best_valid || ($signed(dp_value) > best_score);
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) state <= S_IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        dp_clear  = (state == S_CLEAR);
        row_valid = (state == S_FEED);
        case (state)
            S_IDLE:    if (start) state_nx = S_CLEAR;
            S_CLEAR:   state_nx = S_FEED;
            S_FEED:    if (row_addr == LAST_ROW) state_nx = S_DRAIN;
            S_DRAIN:   if (drain_cnt == '0) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = (neuron_idx == LAST_NEURON) ? S_DONE : S_CLEAR;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            row_addr    <= '0;
            neuron_idx  <= '0;
            drain_cnt   <= '0;
            best_valid  <= 1'b0;
            best_idx    <= '0;
            best_score  <= '0;
            score_valid <= 1'b0;
            score_idx   <= '0;
            score_out   <= '0;
            class_id    <= '0;
            class_score <= '0;
            done        <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            done        <= 1'b0;
            row_addr    <= '0;
            case (state)
                S_IDLE: begin
                    best_valid <= 1'b0;
                    if (start) neuron_idx <= '0;
                end
                S_FEED: begin
                    if (row_addr == LAST_ROW) begin
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        row_addr <= row_addr + 5'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
                end
                S_CAPTURE: begin
                    score_out   <= dp_value;
                    score_idx   <= neuron_idx;
                    score_valid <= 1'b1;
                    if (take_new) begin
                        best_score <= $signed(dp_value);
                        best_idx   <= neuron_idx;
                        best_valid <= 1'b1;
                    end
                    if (neuron_idx != LAST_NEURON) neuron_idx <= neuron_idx + 4'd1;
                end
                S_DONE: begin
                    class_id    <= best_idx;
                    class_score <= best_score;
                    done        <= 1'b1;
                    neuron_idx  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
